zip_wb_resp_mem: RTL and testbench
==================================

// Module: zip_wb_resp_mem
// PURPOSE
// - Pipelined Wishbone slave/memory model that consumes a CPU's bus requests and
//   returns stall/ack/err/data; the downstream stage of a CPU under test in
//   bench and equivalence-check harnesses.
// - Replaces the trivial "ack = stb && !stall" tie-off with real response
//   latency, pseudo-random stall, address decode and an abort-on-cyc-drop rule.
// PARAMETERS
// - AW          30             word-address width of i_wb_addr
// - LGMEM       10             log2 of memory size in 32-bit words
// - BASE        {AW{1'b0}}     word base address; upper AW-LGMEM bits decoded
// - LATENCY     2              accept-to-ack cycles, legal range 1..4
// - SEED        16'hACE1       LFSR reset value, must be nonzero
// PORTS
// - i_clk       in   1      clock
// - i_reset     in   1      synchronous, active-high reset
// - i_wb_cyc    in   1      bus cycle
// - i_wb_stb    in   1      request strobe
// - i_wb_we     in   1      1=write, 0=read
// - i_wb_addr   in   AW     word address
// - i_wb_data   in   32     write data
// - i_wb_sel    in   4      byte enables, bit3 = bits 31:24
// - i_stall_en  in   1      enable pseudo-random stall
// - o_wb_stall  out  1      request not accepted this cycle
// - o_wb_ack    out  1      response, success
// - o_wb_err    out  1      response, bus error (never with o_wb_ack)
// - o_wb_data   out  32     read data, valid with o_wb_ack on reads; 0 otherwise
// BEHAVIOUR
// - Reset: o_wb_ack=0, o_wb_err=0, o_wb_data=0, all pipeline slots invalid,
//   LFSR=SEED. Memory contents not reset. Reset mid-transaction drops all slots.
// - LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle.
// - o_wb_stall = i_stall_en && lfsr[0] (combinational from registered state).
// - accept = i_wb_cyc && i_wb_stb && !o_wb_stall.
// - Decode: hit = (i_wb_addr[AW-1:LGMEM] == BASE[AW-1:LGMEM]); miss -> err.
// - Write on accept&&hit: bytes with i_wb_sel set updated at that clock edge.
// - Read on accept&&hit: memory read at accept edge; write in cycle N visible
//   to read accepted in cycle N+1 or later.
// - Response shift register, LATENCY slots {valid, err, data}; accept cycle N
//   -> exactly one of o_wb_ack/o_wb_err high in cycle N+LATENCY. Responses in
//   request order; one per cycle max; no backpressure needed (never full).
// - Abort: i_wb_cyc low clears every slot valid in that same edge; no ack/err
//   emitted for requests accepted before the drop, even if cyc reasserts.
// - i_wb_stb without i_wb_cyc ignored. Back-to-back accepts every cycle legal.
// CONFIGURATION
// - ZIP_WBMEM_ERRINJ_EN defined: accepted hits with lfsr[4:1]==4'hF respond err
//   (write suppressed); ~1 in 16 requests. Undefined: err only on decode miss.
// STRUCTURE
// - Package zip_wbmem_pkg: resp_t struct {valid, err, data[31:0]}, LFSR tap
//   constant, MAX_LATENCY=4.
// - Sub-module zip_lfsr16 (i_clk, i_reset, SEED -> o_state[15:0]); rest flat.
// TESTING
// - Stall off, LATENCY=2: write 32'hDEADBEEF sel=4'hF @0, read @0 next cycle
//   -> ack 2 cycles after each accept, read data 32'hDEADBEEF.
// - Write 32'h11223344 then sel=4'b0010 write 32'hAABBCCDD, read
//   -> 32'h1122CC44.
// - Address with upper bits != BASE -> o_wb_err at N+LATENCY, o_wb_ack stays 0,
//   memory unchanged.
// - 3 back-to-back reads, drop i_wb_cyc cycle after last accept -> zero acks
//   follow; new cycle's read acks normally.
// - i_stall_en=1 with 100 requests -> acks == accepts, order preserved, stall
//   sequence matches SEED-driven LFSR model.
// - i_reset pulse with 2 responses in flight -> no ack/err afterwards, outputs 0
//   next cycle; with ZIP_WBMEM_ERRINJ_EN, err count matches LFSR model.

Source files
------------

// File: rtl/zip_wbmem_pkg.sv
// Shared types and constants for the pipelined Wishbone response memory.
package zip_wbmem_pkg;

  localparam int          MAX_LATENCY = 4;
  // Right-shifting Fibonacci form of taps 16,14,13,11 (state bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS   = 16'h002D;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/zip_lfsr16.sv
// 16-bit Fibonacci LFSR; loads SEED on reset, then advances every clock.
module zip_lfsr16
  import zip_wbmem_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [15:0] o_state
);

  always_ff @(posedge i_clk) begin
    if (i_reset) o_state <= SEED;
    else         o_state <= lfsr_next(o_state);
  end

endmodule

// File: rtl/zip_wb_resp_mem.sv
// Pipelined Wishbone memory: ack/err exactly LATENCY cycles after accept, pseudo-random stall,
// no backpressure on responses; ZIP_WBMEM_ERRINJ_EN adds LFSR-driven error injection.
module zip_wb_resp_mem
  import zip_wbmem_pkg::*;
#(
  parameter int              AW      = 30,
  parameter int              LGMEM   = 10,
  parameter logic [AW-1:0]   BASE    = {AW{1'b0}},
  parameter int              LATENCY = 2,
  parameter logic [15:0]     SEED    = 16'hACE1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [31:0]   i_wb_data,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_stall_en,
  output logic          o_wb_stall,
  output logic          o_wb_ack,
  output logic          o_wb_err,
  output logic [31:0]   o_wb_data
);

  logic [15:0]      lfsr;
  logic             lfsr_unused;
  logic             accept;
  logic             hit;
  logic             inject;
  logic             req_err;
  logic [LGMEM-1:0] idx;
  logic [31:0]      mem [1<<LGMEM];
  resp_t            slot [LATENCY];
  resp_t            new_resp;
  resp_t            head;

  zip_lfsr16 #(.SEED(SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_state (lfsr)
  );

  assign lfsr_unused = ^lfsr;

  assign o_wb_stall = i_stall_en && lfsr[0];
  assign accept     = i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign hit        = (i_wb_addr[AW-1:LGMEM] == BASE[AW-1:LGMEM]);
  assign idx        = i_wb_addr[LGMEM-1:0];

`ifdef ZIP_WBMEM_ERRINJ_EN
  assign inject = (lfsr[4:1] == 4'hF);
`else
  assign inject = 1'b0;
`endif

  assign req_err = !hit || inject;

  always_ff @(posedge i_clk) begin
    if (accept && i_wb_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wb_sel[b]) mem[idx][8*b +: 8] <= i_wb_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    new_resp       = '0;
    new_resp.valid = 1'b1;
    new_resp.err   = req_err;
    if (!req_err && !i_wb_we) new_resp.data = mem[idx];
  end

  // Dropping cyc aborts everything in flight, so the shift register is simply wiped.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wb_cyc) begin
      for (int i = 0; i < LATENCY; i++) slot[i] <= '0;
    end else begin
      slot[0] <= accept ? new_resp : '0;
      for (int i = 1; i < LATENCY; i++) slot[i] <= slot[i-1];
    end
  end

  // A response landing in the very cycle cyc drops belongs to the aborted cycle, so it is masked.
  assign head      = slot[LATENCY-1];
  assign o_wb_ack  = i_wb_cyc && head.valid && !head.err;
  assign o_wb_err  = i_wb_cyc && head.valid &&  head.err;
  assign o_wb_data = o_wb_ack ? head.data : 32'h0;

endmodule

// File: tb/tb_zip_wb_resp_mem.sv
// Bench for zip_wb_resp_mem: directed vector table plus randomized traffic against a queue-based model.
module tb_zip_wb_resp_mem;

  localparam int          LAT  = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [29:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic [3:0]  i_wb_sel;
  logic        i_stall_en;
  logic        o_wb_stall;
  logic        o_wb_ack;
  logic        o_wb_err;
  logic [31:0] o_wb_data;

  int n_checks = 0;
  int n_errors = 0;

  zip_wb_resp_mem #(.AW(30), .LGMEM(10), .BASE(30'h0), .LATENCY(LAT), .SEED(SEED)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wb_cyc   (i_wb_cyc),
    .i_wb_stb   (i_wb_stb),
    .i_wb_we    (i_wb_we),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .i_wb_sel   (i_wb_sel),
    .i_stall_en (i_stall_en),
    .o_wb_stall (o_wb_stall),
    .o_wb_ack   (o_wb_ack),
    .o_wb_err   (o_wb_err),
    .o_wb_data  (o_wb_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending responses carry the cycle they are due in.
  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
    bit          known;
  } pend_t;

  pend_t       q[$];
  logic [31:0] mmem   [1024];
  bit          mknown [1024];
  logic [15:0] mlfsr;
  int          cyc_n     = 0;
  int          m_accepts = 0;
  int          m_resps   = 0;
  int          m_err_exp = 0;
  int          m_err_obs = 0;

  always @(negedge i_clk) begin
    logic        e_stall, e_ack, e_err, known, acc, hit, inj, rerr;
    logic [31:0] e_data, rdat;
    logic [9:0]  ix;
    pend_t       p;
    if (i_reset) begin
      q.delete();
      mlfsr = SEED;
    end else begin
      e_stall = i_stall_en && mlfsr[0];
      chk("stall", {31'h0, o_wb_stall}, {31'h0, e_stall});
      e_ack = 1'b0; e_err = 1'b0; e_data = 32'h0; known = 1'b1;
      if (q.size() > 0 && q[0].due == cyc_n) begin
        p = q.pop_front();
        if (i_wb_cyc) begin
          e_ack = !p.err; e_err = p.err; e_data = p.err ? 32'h0 : p.data; known = p.known;
        end
      end
      chk("ack", {31'h0, o_wb_ack}, {31'h0, e_ack});
      chk("err", {31'h0, o_wb_err}, {31'h0, e_err});
      if (known) chk("rdata", o_wb_data, e_data);
      if (o_wb_ack || o_wb_err) m_resps++;
      if (o_wb_err) m_err_obs++;
      acc = i_wb_cyc && i_wb_stb && !e_stall;
      if (!i_wb_cyc) q.delete();
      else if (acc) begin
        m_accepts++;
        hit = (i_wb_addr[29:10] == 20'h0);
`ifdef ZIP_WBMEM_ERRINJ_EN
        inj = (mlfsr[4:1] == 4'hF);
`else
        inj = 1'b0;
`endif
        rerr = !hit || inj;
        ix   = i_wb_addr[9:0];
        rdat = 32'h0;
        p.known = 1'b1;
        if (!rerr && i_wb_we) begin
          for (int b = 0; b < 4; b++)
            if (i_wb_sel[b]) mmem[ix][8*b +: 8] = i_wb_data[8*b +: 8];
          if (i_wb_sel == 4'hF) mknown[ix] = 1'b1;
        end else if (!rerr) begin
          rdat    = mmem[ix];
          p.known = mknown[ix];
        end
        if (rerr) m_err_exp++;
        p.due  = cyc_n + LAT;
        p.err  = rerr;
        p.data = rdat;
        q.push_back(p);
      end
      mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
    end
    cyc_n++;
  end

  typedef struct {
    logic        cyc, stb, we;
    logic [29:0] addr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        ack, err;
    logic [31:0] rdat;
  } vec_t;

  vec_t tbl [21];

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc0, resp0, err_exp0, err_obs0, budget;
    logic [31:0] r;

    tbl[0]  = '{1, 1, 1, 30'h000, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0};
    tbl[1]  = '{1, 1, 0, 30'h000, 32'h0,        4'hF, 0, 0, 32'h0};
    tbl[2]  = '{1, 1, 1, 30'h001, 32'h11223344, 4'hF, 1, 0, 32'h0};
    tbl[3]  = '{1, 1, 1, 30'h001, 32'hAABBCCDD, 4'h2, 1, 0, 32'hDEADBEEF};
    tbl[4]  = '{1, 1, 0, 30'h001, 32'h0,        4'hF, 1, 0, 32'h0};
    tbl[5]  = '{1, 1, 1, 30'h401, 32'hFFFFFFFF, 4'hF, 1, 0, 32'h0};
    tbl[6]  = '{1, 1, 0, 30'h001, 32'h0,        4'hF, 1, 0, 32'h1122CC44};
    tbl[7]  = '{1, 0, 0, 30'h000, 32'h0,        4'h0, 0, 1, 32'h0};
    tbl[8]  = '{1, 0, 0, 30'h000, 32'h0,        4'h0, 1, 0, 32'h1122CC44};
    tbl[9]  = '{1, 1, 0, 30'h000, 32'h0,        4'hF, 0, 0, 32'h0};
    tbl[10] = '{1, 1, 0, 30'h001, 32'h0,        4'hF, 0, 0, 32'h0};
    tbl[11] = '{1, 1, 0, 30'h000, 32'h0,        4'hF, 1, 0, 32'hDEADBEEF};
    tbl[12] = '{0, 0, 0, 30'h000, 32'h0,        4'h0, 0, 0, 32'h0};
    tbl[13] = '{0, 1, 1, 30'h000, 32'h0,        4'hF, 0, 0, 32'h0};
    tbl[14] = '{1, 0, 0, 30'h000, 32'h0,        4'h0, 0, 0, 32'h0};
    tbl[15] = '{1, 1, 0, 30'h001, 32'h0,        4'hF, 0, 0, 32'h0};
    tbl[16] = '{1, 0, 0, 30'h000, 32'h0,        4'h0, 0, 0, 32'h0};
    tbl[17] = '{1, 0, 0, 30'h000, 32'h0,        4'h0, 1, 0, 32'h1122CC44};
    tbl[18] = '{1, 1, 0, 30'h000, 32'h0,        4'hF, 0, 0, 32'h0};
    tbl[19] = '{1, 0, 0, 30'h000, 32'h0,        4'h0, 0, 0, 32'h0};
    tbl[20] = '{1, 0, 0, 30'h000, 32'h0,        4'h0, 1, 0, 32'hDEADBEEF};

    i_reset = 1'b1; i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_addr = '0; i_wb_data = '0; i_wb_sel = '0; i_stall_en = 1'b0;
    step(); step();

    // First cycle out of reset: LFSR holds SEED, whose bit 0 is set.
    i_reset = 1'b0; i_stall_en = 1'b1;
    #3;
    chk("reset_ack",   {31'h0, o_wb_ack}, 32'h0);
    chk("reset_err",   {31'h0, o_wb_err}, 32'h0);
    chk("reset_data",  o_wb_data, 32'h0);
    chk("reset_stall", {31'h0, o_wb_stall}, 32'h1);
    step();
    i_stall_en = 1'b0;

    for (int i = 0; i < 21; i++) begin
      i_wb_cyc = tbl[i].cyc; i_wb_stb = tbl[i].stb; i_wb_we = tbl[i].we;
      i_wb_addr = tbl[i].addr; i_wb_data = tbl[i].wdat; i_wb_sel = tbl[i].sel;
      #3;
`ifndef ZIP_WBMEM_ERRINJ_EN
      chk($sformatf("vec%0d_ack", i),  {31'h0, o_wb_ack}, {31'h0, tbl[i].ack});
      chk($sformatf("vec%0d_err", i),  {31'h0, o_wb_err}, {31'h0, tbl[i].err});
      chk($sformatf("vec%0d_data", i), o_wb_data, tbl[i].rdat);
`endif
      step();
    end

    // Randomized traffic with stall enabled; cyc held so every accept must be answered.
    i_stall_en = 1'b1; i_wb_cyc = 1'b1; i_wb_stb = 1'b0;
    step();
    acc0 = m_accepts; resp0 = m_resps; err_exp0 = m_err_exp; err_obs0 = m_err_obs;
    budget = 0;
    while (m_accepts - acc0 < 100 && budget < 5000) begin
      r = $urandom;
      i_wb_stb  = (r[1:0] != 2'b00);
      i_wb_we   = r[2];
      i_wb_sel  = r[6:3];
      i_wb_addr = {19'h0, (r[9:7] == 3'b000), 6'h0, r[13:10]};
      i_wb_data = $urandom;
      step();
      budget++;
    end
    if (m_accepts - acc0 > 100) i_wb_stb = 1'b0;
    chk("rand_accepts", m_accepts - acc0, 100);
    i_wb_stb = 1'b0;
    for (int i = 0; i < LAT + 2; i++) step();
    chk("rand_acks_eq_accepts", m_resps - resp0, m_accepts - acc0);
    chk("rand_err_count", m_err_obs - err_obs0, m_err_exp - err_exp0);

    // Reset with two reads in flight: nothing may come out afterwards.
    i_stall_en = 1'b0;
    i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 30'h000;
    step();
    i_wb_addr = 30'h001;
    step();
    i_wb_stb = 1'b0; i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk($sformatf("post_reset%0d_ack", i),  {31'h0, o_wb_ack}, 32'h0);
      chk($sformatf("post_reset%0d_err", i),  {31'h0, o_wb_err}, 32'h0);
      chk($sformatf("post_reset%0d_data", i), o_wb_data, 32'h0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
